// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NREQ requesters; ack/result arrive two cycles after the grant-eligible req.
// Requesters hold req (and operands) until ack; ALU_ARB_STATS_EN adds per-requester grant and stall counters.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0][31:0]  req_porta,
  input  logic [NREQ-1:0][31:0]  req_portb,
  input  logic [NREQ-1:0][3:0]   req_aluop,
  output logic [NREQ-1:0]        ack,
  output logic [31:0]            result,
  output logic                   zero_f,
  output logic                   neg_f,
  output logic                   ovf_f,
  output logic                   busy,
  output logic [31:0]            alu_porta,
  output logic [31:0]            alu_portb,
  output logic [3:0]             alu_aluop,
  input  logic [31:0]            alu_out,
  input  logic                   alu_zero,
  input  logic                   alu_neg,
  input  logic                   alu_ovf
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][15:0]  grant_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [NREQ-1:0] r_ack;
  logic            r_busy;
  logic [31:0]     r_porta;
  logic [31:0]     r_portb;
  logic [3:0]      r_aluop;
  logic [31:0]     r_result;
  logic            r_zero;
  logic            r_neg;
  logic            r_ovf;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_rot;
  logic [IW:0]     w_off;
  logic [IW:0]     w_sum;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_ptr_nxt;
  logic            w_vld;

  // A requester in its ack cycle still has req high; mask it so its old op is not replayed.
  assign w_elig = req & ~r_ack;
  assign w_rot  = NREQ'({w_elig, w_elig} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = (IW+1)'(j);
    end
  end

  assign w_sum     = {1'b0, r_ptr} + w_off;
  assign w_idx     = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
  assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_vld     = (r_state == S_IDLE) && (w_elig != '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_porta  <= '0;
      r_portb  <= '0;
      r_aluop  <= 4'h0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_vld) begin
            r_porta <= req_porta[w_idx];
            r_portb <= req_portb[w_idx];
            r_aluop <= req_aluop[w_idx];
            r_owner <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result       <= alu_out;
          r_zero         <= alu_zero;
          r_neg          <= alu_neg;
          r_ovf          <= alu_ovf;
          r_ack[r_owner] <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign result    = r_result;
  assign zero_f    = r_zero;
  assign neg_f     = r_neg;
  assign ovf_f     = r_ovf;
  assign busy      = r_busy;
  assign alu_porta = r_porta;
  assign alu_portb = r_portb;
  assign alu_aluop = r_aluop;

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0]       w_gnt;
  logic [NREQ-1:0][15:0] r_gcnt;
  logic [15:0]           r_scnt;

  assign w_gnt = w_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << w_idx) : '0;

  // Grants are counted on the completing edge, so they track acks exactly.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_gcnt <= '0;
      r_scnt <= '0;
    end else begin
      if ((r_state == S_EXEC) && (r_gcnt[r_owner] != 16'hFFFF))
        r_gcnt[r_owner] <= r_gcnt[r_owner] + 16'd1;
      if (((req & ~r_ack & ~w_gnt) != '0) && (r_scnt != 16'hFFFF))
        r_scnt <= r_scnt + 16'd1;
    end
  end

  assign grant_cnt = r_gcnt;
  assign stall_cnt = r_scnt;
`endif

endmodule
